// File: rtl/dna_pkg.sv
// Shared definitions for the DNA syndrome stream: symbol type, the
// nucleotide encodings and the syndrome engine state enum.
package dna_pkg;

    typedef logic [1:0] sym_t;

    localparam sym_t SYM_A = 2'd0;
    localparam sym_t SYM_C = 2'd1;
    localparam sym_t SYM_G = 2'd2;
    localparam sym_t SYM_T = 2'd3;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } syn_state_t;

endpackage

// File: rtl/dna_sym_hist.sv
// Per-word symbol histogram. Holds one counter per symbol value and reports
// how many symbols already seen in the word are strictly greater than i_sym,
// which is the inversion increment contributed by i_sym.
module dna_sym_hist
    import dna_pkg::*;
#(
    parameter int N = 6
) (
    input  logic                       clk,
    input  logic                       i_clr,
    input  logic                       i_inc,
    input  sym_t                       i_sym,
    output logic [$clog2(N+1)-1:0]     o_gt_cnt
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] r_hist [4];

    // Count accepted symbols per value; clear wins over increment.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int v = 0; v < 4; v++) begin
                r_hist[v] <= '0;
            end
        end else if (i_inc) begin
            r_hist[i_sym] <= r_hist[i_sym] + CW'(1);
        end
    end

    // Sum the counters above i_sym; total is bounded by N-1 so CW bits suffice.
    always_comb begin
        o_gt_cnt = '0;
        for (int v = 0; v < 4; v++) begin
            if (2'(v) > i_sym) begin
                o_gt_cnt = o_gt_cnt + r_hist[v];
            end
        end
    end

endmodule

// File: rtl/dna_syn_stream.sv
// Streaming inversion / VT syndrome engine for N-symbol quaternary words.
// Optional macro DNA_SYN_MOD_EN: keep both sums as residues mod MOD;
// without it the sums wrap modulo 2^OUT_W and MOD is only range-checked.
module dna_syn_stream
    import dna_pkg::*;
#(
    parameter int N     = 6,
    parameter int OUT_W = 14,
    parameter int MOD   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sym,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] inv_sum,
    output logic [OUT_W-1:0] vt_sum,
    output logic             frame_err
);

    localparam int IW = $clog2(N + 1);
    localparam int VW = $clog2(3 * N + 1);

    if (N < 2 || MOD < 2) begin : g_param_chk
        $error("dna_syn_stream: N and MOD must both be at least 2");
    end

    syn_state_t       r_state;
    syn_state_t       w_next;
    logic [IW-1:0]    r_idx;
    logic [OUT_W-1:0] r_inv;
    logic [OUT_W-1:0] r_vt;
    logic             r_ferr;

    logic             w_xfer;
    logic             w_done;
    logic             w_last_idx;
    logic             w_close;
    logic [IW-1:0]    w_gt;
    logic [VW-1:0]    w_vt_inc;
    logic [OUT_W-1:0] w_inv_nx;
    logic [OUT_W-1:0] w_vt_nx;

    assign w_xfer     = in_valid && in_ready;
    assign w_done     = out_valid && out_ready;
    assign w_last_idx = (r_idx == IW'(N));
    assign w_close    = w_xfer && (w_last_idx || in_last);
    // i*s never exceeds 3N, so VW bits hold the product exactly.
    assign w_vt_inc   = VW'(r_idx) * VW'(in_sym);

    dna_sym_hist #(.N(N)) u_hist (
        .clk      (clk),
        .i_clr    (rst || w_done),
        .i_inc    (w_xfer),
        .i_sym    (sym_t'(in_sym)),
        .o_gt_cnt (w_gt)
    );

`ifdef DNA_SYN_MOD_EN
    localparam logic [OUT_W:0] MOD_W = (OUT_W + 1)'(MOD);

    // Fold a raw increment into [0, MOD).
    function automatic logic [OUT_W-1:0] mod_reduce(input logic [31:0] x);
        return OUT_W'(x % MOD);
    endfunction

    // Add two residues; one conditional subtract keeps the result below MOD.
    function automatic logic [OUT_W-1:0] mod_add(input logic [OUT_W-1:0] acc,
                                                 input logic [OUT_W-1:0] inc);
        logic [OUT_W:0] s;
        s = {1'b0, acc} + {1'b0, inc};
        if (s >= MOD_W) begin
            s = s - MOD_W;
        end
        return s[OUT_W-1:0];
    endfunction

    assign w_inv_nx = mod_add(r_inv, mod_reduce(32'(w_gt)));
    assign w_vt_nx  = mod_add(r_vt, mod_reduce(32'(w_vt_inc)));
`else
    assign w_inv_nx = r_inv + OUT_W'(w_gt);
    assign w_vt_nx  = r_vt + OUT_W'(w_vt_inc);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: close a word into HOLD, leave HOLD on the output handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ACCUM:   if (w_close)   w_next = HOLD;
            HOLD:    if (out_ready) w_next = ACCUM;
            default: w_next = ACCUM;
        endcase
    end

    // Handshake outputs decoded from state.
    always_comb begin
        in_ready  = (r_state == ACCUM);
        out_valid = (r_state == HOLD);
    end

    // Index and syndrome accumulators; the word restarts at index 1 on reset or handshake.
    always_ff @(posedge clk) begin
        if (rst || w_done) begin
            r_idx  <= IW'(1);
            r_inv  <= '0;
            r_vt   <= '0;
            r_ferr <= 1'b0;
        end else if (w_xfer) begin
            r_idx <= r_idx + IW'(1);
            r_inv <= w_inv_nx;
            r_vt  <= w_vt_nx;
            if (w_close) begin
                // Framing is wrong exactly when in_last and "index reached N" disagree.
                r_ferr <= in_last ^ w_last_idx;
            end
        end
    end

    assign inv_sum   = r_inv;
    assign vt_sum    = r_vt;
    assign frame_err = r_ferr;

endmodule
